// File: rtl/regfile_pkg.sv
// Shared definitions for the general-purpose register file: default geometry
// and the address/data types used by the datapath around it.
package regfile_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int NUM_REGS_DEF = 16;
    localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [WIDTH_DEF-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_entry.sv
// One register-file entry: a storage word plus its busy (pending write) bit.
// A set and a load in the same cycle leave the entry busy, because the set
// belongs to a newer instruction than the one writing back now.
module regfile_entry
    import regfile_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             set,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    // Storage word: loaded on write-back, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            q <= '0;
        else if (load)
            q <= d;
    end

    // Busy bit: set at issue, cleared at write-back, issue takes priority.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            busy <= 1'b0;
        else if (set)
            busy <= 1'b1;
        else if (load)
            busy <= 1'b0;
    end

endmodule

// File: rtl/gen_register_file.sv
// Parametrised register file with one write port, two combinational read
// ports and a per-entry busy scoreboard for read-after-write stalls.
// Optional build macro: GEN_REGFILE_BYPASS_EN enables write-through
// forwarding from the write port to both read ports in the same cycle.
module gen_register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    // Derived from NUM_REGS; leave at its default.
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int R0_ZERO  = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_addr,
    input  logic [ADDR_W-1:0]   rd_a_addr,
    output logic [WIDTH-1:0]    rd_a_data,
    output logic                rd_a_busy,
    input  logic [ADDR_W-1:0]   rd_b_addr,
    output logic [WIDTH-1:0]    rd_b_data,
    output logic                rd_b_busy,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [WIDTH-1:0]    data_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    // An address is live if it names a real entry and is not the hardwired zero.
    function automatic logic live(input logic [ADDR_W-1:0] a);
        return (int'(a) < NUM_REGS) && !((R0_ZERO != 0) && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] read_data(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (live(a))
            v = data_q[a];
`ifdef GEN_REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == a) && live(a))
            v = wr_data;
`endif
        return v;
    endfunction

    function automatic logic read_busy(input logic [ADDR_W-1:0] a);
        logic v;
        v = 1'b0;
        if (live(a))
            v = busy_q[a];
`ifdef GEN_REGFILE_BYPASS_EN
        // A forwarded write retires the pending result, unless a newer
        // issue to the same entry lands on the same edge.
        if (wr_en && (wr_addr == a) && live(a))
            v = issue_en && (issue_addr == a);
`endif
        return v;
    endfunction

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        if ((R0_ZERO != 0) && (i == 0)) begin : g_zero
            assign data_q[i] = '0;
            assign busy_q[i] = 1'b0;
        end else begin : g_reg
            logic load;
            logic set;
            assign load = wr_en    && (wr_addr    == ADDR_W'(i));
            assign set  = issue_en && (issue_addr == ADDR_W'(i));
            regfile_entry #(.WIDTH(WIDTH)) u_entry (
                .clk  (clk),
                .clr  (clr),
                .load (load),
                .d    (wr_data),
                .set  (set),
                .q    (data_q[i]),
                .busy (busy_q[i])
            );
        end
    end

    // Read ports: independent muxes over stored state (plus forwarding if built in).
    always_comb begin
        rd_a_data = read_data(rd_a_addr);
        rd_a_busy = read_busy(rd_a_addr);
        rd_b_data = read_data(rd_b_addr);
        rd_b_busy = read_busy(rd_b_addr);
    end

    assign busy_vec = busy_q;

endmodule
